// File: rtl/pool2d_multi_with_mem.sv
// Multi-channel max/average 2-D pooling engine that streams each window over
// the shared tri-state memory bus and writes one result per window.
module pool2d_multi_with_mem #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int DATABUS_WIDTH = 32,
  parameter int CHANNELS      = 2,
  parameter int HEIGHT        = 4,
  parameter int WIDTH         = 4,
  parameter int POOL_SIZE     = 2,
  parameter int STRIDE        = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     mode,
  input  logic [ADDR_WIDTH-1:0]    input_addr,
  input  logic [ADDR_WIDTH-1:0]    output_addr,
  output logic                     busy,
  output logic                     done,
  output logic                     mem_w,
  output logic                     mem_sel,
  inout  wire  [ADDR_WIDTH-1:0]    address_bus,
  inout  wire  [DATABUS_WIDTH-1:0] data_bus
);

  localparam int AREA  = POOL_SIZE * POOL_SIZE;
  localparam int ACC_W = DATA_WIDTH + $clog2(AREA + 1);
  localparam int OUT_H = (HEIGHT - POOL_SIZE) / STRIDE + 1;
  localparam int OUT_W = (WIDTH - POOL_SIZE) / STRIDE + 1;
  localparam int CNT_W = $clog2(CHANNELS + HEIGHT + WIDTH + 2);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t                 state_q;
  logic                   mode_q, busy_q, done_q, memW_q, memSel_q;
  logic [ADDR_WIDTH-1:0]  inBase_q, outBase_q, addr_q;
  logic [DATA_WIDTH-1:0]  wdata_q;
  logic [ACC_W-1:0]       acc_q;
  logic [CNT_W-1:0]       ch_q, oy_q, ox_q, wy_q, wx_q;

  logic [CNT_W-1:0]       ch_d, oy_d, ox_d, wy_d, wx_d;
  logic [ACC_W-1:0]       acc_d, sumNext, maxNext;
  logic [DATA_WIDTH-1:0]  result_d, elem;
  logic                   firstElem, lastElem, lastOut;

  function automatic logic [ADDR_WIDTH-1:0] inAddr(input logic [CNT_W-1:0] c, oy, ox, wy, wx);
    logic [31:0] off;
    off = 32'(c) * 32'(HEIGHT * WIDTH)
        + (32'(oy) * 32'(STRIDE) + 32'(wy)) * 32'(WIDTH)
        + 32'(ox) * 32'(STRIDE) + 32'(wx);
    return inBase_q + ADDR_WIDTH'(off);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] outAddr(input logic [CNT_W-1:0] c, oy, ox);
    logic [31:0] off;
    off = 32'(c) * 32'(OUT_H * OUT_W) + 32'(oy) * 32'(OUT_W) + 32'(ox);
    return outBase_q + ADDR_WIDTH'(off);
  endfunction

  // The first element of a window seeds the accumulator, so no separate clear is needed for max.
  always_comb begin
    elem      = data_bus[DATA_WIDTH-1:0];
    firstElem = (wy_q == '0) && (wx_q == '0);
    sumNext   = (firstElem ? '0 : acc_q) + ACC_W'(elem);
    maxNext   = (firstElem || (ACC_W'(elem) > acc_q)) ? ACC_W'(elem) : acc_q;
    acc_d     = mode_q ? sumNext : maxNext;
    result_d  = mode_q ? DATA_WIDTH'(sumNext / ACC_W'(AREA)) : DATA_WIDTH'(maxNext);

    wx_d = wx_q + CNT_W'(1);
    wy_d = wy_q;
    if (wx_q == CNT_W'(POOL_SIZE - 1)) begin
      wx_d = '0;
      wy_d = wy_q + CNT_W'(1);
    end
    lastElem = (wx_q == CNT_W'(POOL_SIZE - 1)) && (wy_q == CNT_W'(POOL_SIZE - 1));

    ox_d = ox_q + CNT_W'(1);
    oy_d = oy_q;
    ch_d = ch_q;
    if (ox_q == CNT_W'(OUT_W - 1)) begin
      ox_d = '0;
      oy_d = oy_q + CNT_W'(1);
      if (oy_q == CNT_W'(OUT_H - 1)) begin
        oy_d = '0;
        ch_d = ch_q + CNT_W'(1);
      end
    end
    lastOut = (ox_q == CNT_W'(OUT_W - 1)) && (oy_q == CNT_W'(OUT_H - 1)) &&
              (ch_q == CNT_W'(CHANNELS - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      memW_q    <= 1'b0;
      memSel_q  <= 1'b0;
      inBase_q  <= '0;
      outBase_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      acc_q     <= '0;
      ch_q      <= '0;
      oy_q      <= '0;
      ox_q      <= '0;
      wy_q      <= '0;
      wx_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            mode_q    <= mode;
            inBase_q  <= input_addr;
            outBase_q <= output_addr;
            ch_q      <= '0;
            oy_q      <= '0;
            ox_q      <= '0;
            wy_q      <= '0;
            wx_q      <= '0;
            acc_q     <= '0;
            memSel_q  <= 1'b1;
            memW_q    <= 1'b0;
            busy_q    <= 1'b1;
            addr_q    <= input_addr;
            state_q   <= READ;
          end
        end
        READ: begin
          acc_q <= acc_d;
          if (lastElem) begin
            wx_q    <= '0;
            wy_q    <= '0;
            memW_q  <= 1'b1;
            addr_q  <= outAddr(ch_q, oy_q, ox_q);
            wdata_q <= result_d;
            state_q <= WRITE;
          end else begin
            wx_q   <= wx_d;
            wy_q   <= wy_d;
            addr_q <= inAddr(ch_q, oy_q, ox_q, wy_d, wx_d);
          end
        end
        WRITE: begin
          memW_q <= 1'b0;
          acc_q  <= '0;
          if (lastOut) begin
            memSel_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            ch_q    <= ch_d;
            oy_q    <= oy_d;
            ox_q    <= ox_d;
            addr_q  <= inAddr(ch_d, oy_d, ox_d, '0, '0);
            state_q <= READ;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign mem_w       = memW_q;
  assign mem_sel     = memSel_q;
  assign address_bus = memSel_q ? addr_q : 'z;
  assign data_bus    = (memSel_q && memW_q) ? DATABUS_WIDTH'(wdata_q) : 'z;

  // Upper data-bus bits carry nothing for this block on reads.
  generate
    if (DATABUS_WIDTH > DATA_WIDTH) begin : gUnused
      logic unusedBits;
      assign unusedBits = ^data_bus[DATABUS_WIDTH-1:DATA_WIDTH];
    end
  endgenerate

endmodule

// File: tb/tb_pool2d_multi_with_mem.sv
// Self-checking bench: two engine configurations, each on its own bus with a
// behavioural memory, checked against a window-by-window pooling model.
module tb_pool2d_multi_with_mem;

  localparam int CHA = 2, HA = 4, WA = 4, PA = 2, SA = 2;
  localparam int CHB = 1, HB = 4, WB = 4, PB = 3, SB = 1;
  localparam int TOTA = CHA * ((HA - PA) / SA + 1) * ((WA - PA) / SA + 1) * (PA * PA + 1);
  localparam int TOTB = CHB * ((HB - PB) / SB + 1) * ((WB - PB) / SB + 1) * (PB * PB + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic        startA, modeA, busyA, doneA, wA, selA;
  logic [7:0]  inA, outA;
  wire  [7:0]  addrA;
  wire  [31:0] dataA;
  logic        startB, modeB, busyB, doneB, wB, selB;
  logic [7:0]  inB, outB;
  wire  [7:0]  addrB;
  wire  [31:0] dataB;

  logic [31:0] memA [256];
  logic [31:0] memB [256];
  logic [7:0]  expAddrA [$];
  logic [31:0] expDataA [$];
  logic [7:0]  expAddrB [$];
  logic [31:0] expDataB [$];

  int checks = 0;
  int failures = 0;
  bit monOn = 1'b0;

  pool2d_multi_with_mem dutA (
    .clk(clk), .rst(rst), .start(startA), .mode(modeA),
    .input_addr(inA), .output_addr(outA), .busy(busyA), .done(doneA),
    .mem_w(wA), .mem_sel(selA), .address_bus(addrA), .data_bus(dataA)
  );

  pool2d_multi_with_mem #(.CHANNELS(CHB), .HEIGHT(HB), .WIDTH(WB), .POOL_SIZE(PB), .STRIDE(SB)) dutB (
    .clk(clk), .rst(rst), .start(startB), .mode(modeB),
    .input_addr(inB), .output_addr(outB), .busy(busyB), .done(doneB),
    .mem_w(wB), .mem_sel(selB), .address_bus(addrB), .data_bus(dataB)
  );

  assign dataA = (selA && !wA) ? memA[addrA] : 'z;
  assign dataB = (selB && !wB) ? memB[addrB] : 'z;
  always @(posedge clk) if (selA && wA) memA[addrA] <= dataA;
  always @(posedge clk) if (selB && wB) memB[addrB] <= dataB;

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  function automatic bit released(input logic [7:0] a, input logic [31:0] d);
    return ((a === 8'h00) || $isunknown(a)) && ((d === 32'h0) || $isunknown(d));
  endfunction

  // Bus monitors: every write is checked against the model, reads and idle bus states against the memory.
  always @(negedge clk) if (monOn) begin
    if (selA && wA) begin
      if (expAddrA.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL A_unexpectedWrite actual=write@%0d expected=no write", addrA);
      end else begin
        checkOutput("A_wrAddr", addrA, expAddrA.pop_front());
        checkOutput("A_wrData", dataA, expDataA.pop_front());
      end
    end else if (selA) checkOutput("A_readData", dataA, memA[addrA]);
    else checkOutput("A_busRelease", released(addrA, dataA), 1);
  end

  always @(negedge clk) if (monOn) begin
    if (selB && wB) begin
      if (expAddrB.size() == 0) begin
        checks++; failures++;
        $display("[TB] FAIL B_unexpectedWrite actual=write@%0d expected=no write", addrB);
      end else begin
        checkOutput("B_wrAddr", addrB, expAddrB.pop_front());
        checkOutput("B_wrData", dataB, expDataB.pop_front());
      end
    end else if (selB) checkOutput("B_readData", dataB, memB[addrB]);
    else checkOutput("B_busRelease", released(addrB, dataB), 1);
  end

  task automatic buildModel(input int which, input logic m, input logic [7:0] ib, input logic [7:0] ob);
    int ch, h, w, p, s, oh, ow, mx, sum, v, res;
    logic [7:0] a;
    if (which == 0) begin ch = CHA; h = HA; w = WA; p = PA; s = SA; end
    else begin ch = CHB; h = HB; w = WB; p = PB; s = SB; end
    oh = (h - p) / s + 1;
    ow = (w - p) / s + 1;
    for (int c = 0; c < ch; c++)
      for (int oy = 0; oy < oh; oy++)
        for (int ox = 0; ox < ow; ox++) begin
          mx = 0; sum = 0;
          for (int wy = 0; wy < p; wy++)
            for (int wx = 0; wx < p; wx++) begin
              a = 8'(int'(ib) + c * h * w + (oy * s + wy) * w + ox * s + wx);
              v = (which == 0) ? int'(memA[a][7:0]) : int'(memB[a][7:0]);
              if (v > mx) mx = v;
              sum += v;
            end
          res = m ? sum / (p * p) : mx;
          a = 8'(int'(ob) + c * oh * ow + oy * ow + ox);
          if (which == 0) begin expAddrA.push_back(a); expDataA.push_back(32'(res)); end
          else begin expAddrB.push_back(a); expDataB.push_back(32'(res)); end
        end
  endtask

  task automatic setInputs(input int which, input logic s, input logic m, input logic [7:0] ib, input logic [7:0] ob);
    if (which == 0) begin startA = s; modeA = m; inA = ib; outA = ob; end
    else begin startB = s; modeB = m; inB = ib; outB = ob; end
  endtask

  task automatic fillMem(input int which, input bit directed);
    logic [7:0] v;
    for (int i = 0; i < 256; i++) begin
      v = 8'($urandom);
      if (directed && i < 16) v = 8'(i);
      else if (directed && i < 32) v = 8'hFF;
      if (which == 0) memA[i] = {24'($urandom), v};
      else memB[i] = {24'($urandom), v};
    end
  endtask

  task automatic countJob(input int which, input int disturbAt, input logic m, input logic [7:0] ib,
                          input logic [7:0] ob, output int selCnt, output int doneCyc, output bit bubble);
    int cyc = 0;
    selCnt = 0; doneCyc = 0; bubble = 1'b0;
    while (doneCyc == 0 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
      if (cyc == disturbAt) setInputs(which, 1'b1, ~m, ib + 8'h20, ob + 8'h60);
      if (cyc == 1) checkOutput("busyHigh", (which == 0) ? busyA : busyB, 1);
      if ((which == 0) ? doneA : doneB) doneCyc = cyc;
      else if ((which == 0) ? selA : selB) selCnt++;
      else bubble = 1'b1;
    end
  endtask

  task automatic applyStimulus(input int which, input logic m, input logic [7:0] ib, input logic [7:0] ob, input bit disturb);
    int total, selCnt, doneCyc;
    bit bubble;
    total = (which == 0) ? TOTA : TOTB;
    buildModel(which, m, ib, ob);
    @(negedge clk);
    setInputs(which, 1'b1, m, ib, ob);
    @(posedge clk);
    #1 setInputs(which, 1'b0, m, ib, ob);
    countJob(which, disturb ? 10 : 0, m, ib, ob, selCnt, doneCyc, bubble);
    checkOutput("busCycles", selCnt, total);
    checkOutput("doneCycle", doneCyc, total + 1);
    checkOutput("noBubble", bubble, 0);
    checkOutput("busyAtDone", (which == 0) ? busyA : busyB, 0);
    if (disturb) begin
      // start has been held high since cycle 10 with new mode/bases; it takes effect only after IDLE
      buildModel(which, ~m, ib + 8'h20, ob + 8'h60);
      @(negedge clk);
      checkOutput("idleBusy", (which == 0) ? busyA : busyB, 0);
      checkOutput("singlePulse", (which == 0) ? doneA : doneB, 0);
      @(posedge clk);
      #1 setInputs(which, 1'b0, ~m, ib + 8'h20, ob + 8'h60);
      countJob(which, 0, m, ib, ob, selCnt, doneCyc, bubble);
      checkOutput("chainCycles", selCnt, total);
      checkOutput("chainDone", doneCyc, total + 1);
    end
    @(negedge clk);
    checkOutput("donePulseEnd", (which == 0) ? doneA : doneB, 0);
    checkOutput("pendingWrites", (which == 0) ? expAddrA.size() : expAddrB.size(), 0);
  endtask

  task automatic checkLiterals(input int which, input string name, input int e0, input int e1,
                               input int e2, input int e3, input int e4);
    int lits [5];
    lits = '{e0, e1, e2, e3, e4};
    for (int i = 0; i < ((which == 0) ? 8 : 4); i++)
      checkOutput(name, (which == 0) ? memA[8'h40 + i] : memB[8'h40 + i], (i < 4) ? lits[i] : lits[4]);
  endtask

  task automatic resetMidJob();
    buildModel(0, 1'b0, 8'h00, 8'h40);
    @(negedge clk);
    setInputs(0, 1'b1, 1'b0, 8'h00, 8'h40);
    @(posedge clk);
    #1 setInputs(0, 1'b0, 1'b0, 8'h00, 8'h40);
    repeat (12) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstSel", selA, 0);
    checkOutput("rstBusy", busyA, 0);
    checkOutput("rstDone", doneA, 0);
    checkOutput("rstRelease", released(addrA, dataA), 1);
    rst = 1'b0;
    expAddrA.delete();
    expDataA.delete();
    repeat (20) @(negedge clk);
    checkOutput("postRstSel", selA, 0);
    checkOutput("postRstBusy", busyA, 0);
  endtask

  initial begin
    rst = 1'b1;
    setInputs(0, 1'b0, 1'b0, 8'h00, 8'h40);
    setInputs(1, 1'b0, 1'b0, 8'h00, 8'h40);
    repeat (3) @(negedge clk);
    checkOutput("rstBusyA", busyA, 0);
    checkOutput("rstDoneA", doneA, 0);
    checkOutput("rstSelA", selA, 0);
    checkOutput("rstWA", wA, 0);
    checkOutput("rstBusyB", busyB, 0);
    checkOutput("rstSelB", selB, 0);
    rst = 1'b0;
    monOn = 1'b1;

    fillMem(0, 1'b1);
    applyStimulus(0, 1'b0, 8'h00, 8'h40, 1'b0);
    checkLiterals(0, "litMaxA", 5, 7, 13, 15, 255);
    applyStimulus(0, 1'b1, 8'h00, 8'h40, 1'b0);
    checkLiterals(0, "litAvgA", 2, 4, 10, 12, 255);

    fillMem(1, 1'b1);
    applyStimulus(1, 1'b1, 8'h00, 8'h40, 1'b0);
    checkLiterals(1, "litAvgB", 5, 6, 9, 10, 0);
    applyStimulus(1, 1'b0, 8'h00, 8'h40, 1'b0);
    checkLiterals(1, "litMaxB", 10, 11, 14, 15, 0);

    fillMem(0, 1'b1);
    applyStimulus(0, 1'b0, 8'h00, 8'h40, 1'b1);
    checkLiterals(0, "litDisturbA", 5, 7, 13, 15, 255);

    fillMem(0, 1'b1);
    resetMidJob();
    applyStimulus(0, 1'b1, 8'h00, 8'h40, 1'b0);
    checkLiterals(0, "litAfterRst", 2, 4, 10, 12, 255);

    for (int k = 0; k < 6; k++) begin
      logic [7:0] ib;
      fillMem(0, 1'b0);
      ib = 8'($urandom);
      applyStimulus(0, 1'($urandom_range(0, 1)), ib, ib + 8'h80, 1'b0);
    end
    for (int k = 0; k < 4; k++) begin
      logic [7:0] ib;
      fillMem(1, 1'b0);
      ib = 8'($urandom);
      applyStimulus(1, 1'($urandom_range(0, 1)), ib, ib + 8'h80, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
